module_uart_tx: RTL and testbench

UART transmit register stage directly downstream of the 1-to-2 write demultiplexer. It consumes the two routed write strobes, holding a control register and a data register written from the shared bus data word. It serialises the data register's low byte onto the TX line as an 8N1 frame when software sets the send bit. Both registers read back for the bus read mux.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/module_baud_counter.sv | 29 ++
 rtl/module_uart_tx.sv | 127 ++++++++++++
 tb/tb_module_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, control register layout
// and the helper that packs the control readback word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int CTRL_SEND = 0;
  localparam int CTRL_BUSY = 1;
  localparam int UART_DW   = 8;

  function automatic logic [31:0] ctrl_word(input logic send, input logic busy);
    logic [31:0] word;
    word            = 32'h0000_0000;
    word[CTRL_SEND] = send;
    word[CTRL_BUSY] = busy;
    return word;
  endfunction

endpackage

// File: rtl/module_baud_counter.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and pulses tick on the last count.
// Holding clear keeps it at zero so the first period after release is full length.
module module_baud_counter #(
  parameter int BAUD_DIV = 87
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int               CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt_r == LAST);

endmodule

// File: rtl/module_uart_tx.sv
// UART transmit register stage: control/data registers on the routed write strobes
// and an 8N1 serialiser driving a registered, idle-high TX line.
module module_uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wr1_control_i,
  input  logic        wr1_data_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] control_o,
  output logic [31:0] data_o,
  output logic        tx_o
);

  tx_state_e            state_r, state_next_s;
  logic [UART_DW-1:0]   data_r;
  logic [UART_DW-1:0]   shift_r, shift_next_s;
  logic [2:0]           bit_idx_r, bit_idx_next_s;
  logic                 send_r;
  logic                 tx_r, tx_next_s;
  logic                 tick_s;
  logic                 clear_s;
  logic                 busy_s;
  logic                 accept_ctrl_s;
  logic                 unused_s;

  assign busy_s        = (state_r != IDLE);
  assign clear_s       = (state_r == IDLE);
  assign accept_ctrl_s = wr1_control_i && (state_r == IDLE);
  assign unused_s      = ^wdata_i[31:UART_DW];

  module_baud_counter #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clk  (clk_i),
    .rst_n(rst_n_i),
    .clear(clear_s),
    .tick (tick_s)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      shift_r   <= shift_next_s;
      bit_idx_r <= bit_idx_next_s;
      tx_r      <= tx_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (send_r) state_next_s = START; else state_next_s = IDLE;
      START:   if (tick_s) state_next_s = DATA;  else state_next_s = START;
      DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) state_next_s = STOP;
        else                               state_next_s = DATA;
      end
      STOP:    if (tick_s) state_next_s = IDLE;  else state_next_s = STOP;
      default: state_next_s = IDLE;
    endcase
  end

  // The byte is captured when send is written, so a same-edge data write only affects later frames.
  always_comb begin
    shift_next_s   = shift_r;
    bit_idx_next_s = bit_idx_r;
    tx_next_s      = 1'b1;
    if (accept_ctrl_s && wdata_i[CTRL_SEND]) begin
      shift_next_s = data_r;
    end else if ((state_r == DATA) && tick_s) begin
      shift_next_s = shift_r >> 1;
    end else begin
      shift_next_s = shift_r;
    end
    if (state_r == START) begin
      bit_idx_next_s = 3'd0;
    end else if ((state_r == DATA) && tick_s) begin
      bit_idx_next_s = bit_idx_r + 3'd1;
    end else begin
      bit_idx_next_s = bit_idx_r;
    end
    case (state_next_s)
      IDLE:    tx_next_s = 1'b1;
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_next_s[0];
      STOP:    tx_next_s = 1'b1;
      default: tx_next_s = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_r <= '0;
    end else if (wr1_data_i) begin
      data_r <= wdata_i[UART_DW-1:0];
    end else begin
      data_r <= data_r;
    end
  end

  // send self-clears on the same edge that returns the FSM to IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      send_r <= 1'b0;
    end else if (accept_ctrl_s) begin
      send_r <= wdata_i[CTRL_SEND];
    end else if ((state_r == STOP) && tick_s) begin
      send_r <= 1'b0;
    end else begin
      send_r <= send_r;
    end
  end

  assign control_o = ctrl_word(send_r, busy_s);
  assign data_o    = {24'h00_0000, data_r};
  assign tx_o      = tx_r;

endmodule

// File: tb/tb_module_uart_tx.sv
// Bench for module_uart_tx: two instances (BAUD_DIV 4 and 2) share the bus, a frame-level
// model predicts every output each cycle, and directed captures pin exact bit sequences.
module tb_module_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_c;
  logic        wr_d;
  logic [31:0] wdata;
  logic [31:0] ctl0, dat0, ctl1, dat1;
  logic        tx0, tx1;
  logic        chk_en;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  module_uart_tx #(.BAUD_DIV(4)) u_dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .wr1_control_i(wr_c), .wr1_data_i(wr_d),
    .wdata_i(wdata), .control_o(ctl0), .data_o(dat0), .tx_o(tx0)
  );

  module_uart_tx #(.BAUD_DIV(2)) u_dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .wr1_control_i(wr_c), .wr1_data_i(wr_d),
    .wdata_i(wdata), .control_o(ctl1), .data_o(dat1), .tx_o(tx1)
  );

  function automatic int bd(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic tx_of(input int k);
    return (k == 0) ? tx0 : tx1;
  endfunction

  function automatic logic [31:0] ctl_of(input int k);
    return (k == 0) ? ctl0 : ctl1;
  endfunction

  // Frame-level model: a frame is 10 bit slots of bd(k) cycles each.
  logic [7:0] m_data[2];
  logic [7:0] m_byte[2];
  logic       m_send[2];
  logic       m_active[2];
  logic       m_was[2];
  int         m_pos[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_data[k] = 8'h00; m_byte[k] = 8'h00; m_send[k] = 1'b0;
        m_active[k] = 1'b0; m_pos[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_was[k] = m_active[k];
        if (m_active[k]) begin
          m_pos[k] = m_pos[k] + 1;
          if (m_pos[k] == 10 * bd(k)) begin
            m_active[k] = 1'b0;
            m_send[k]   = 1'b0;
          end
        end else if (m_send[k]) begin
          m_active[k] = 1'b1;
          m_pos[k]    = 0;
        end
        if (wr_c && !m_was[k]) begin
          m_send[k] = wdata[0];
          if (wdata[0]) m_byte[k] = m_data[k];
        end
        if (wr_d) m_data[k] = wdata[7:0];
      end
    end
  end

  function automatic logic m_tx(input int k);
    int idx;
    if (!m_active[k]) return 1'b1;
    idx = m_pos[k] / bd(k);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[k][idx-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    cmp_cnt++;
    err_cnt++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_b4",   {31'h0, tx0}, {31'h0, m_tx(0)});
      chk("ctl_b4",  ctl0, {30'h0, m_active[0], m_send[0]});
      chk("data_b4", dat0, {24'h0, m_data[0]});
      chk("tx_b2",   {31'h0, tx1}, {31'h0, m_tx(1)});
      chk("ctl_b2",  ctl1, {30'h0, m_active[1], m_send[1]});
      chk("data_b2", dat1, {24'h0, m_data[1]});
    end
  end

  task automatic bus_write(input logic c, input logic d, input logic [31:0] v);
    @(negedge clk);
    wr_c = c; wr_d = d; wdata = v;
    @(negedge clk);
    wr_c = 1'b0; wr_d = 1'b0; wdata = 32'h0;
  endtask

  // Samples one whole frame on instance k; exp[i] is the i-th bit on the line.
  task automatic capture(input int k, input logic [9:0] exp, input string name);
    int         b;
    int         waited;
    int         busy_n;
    logic       stable;
    logic [9:0] got;
    logic       s;
    b = bd(k); waited = 0; busy_n = 0; stable = 1'b1; got = 10'h000;
    while (!ctl_of(k)[1] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ctl_of(k)[1]) begin
      timeout({name, "_start"});
      return;
    end
    for (int i = 0; i < 10 * b; i++) begin
      if (i > 0) @(negedge clk);
      s = tx_of(k);
      if (i % b == 0) got[i / b] = s;
      else if (s !== got[i / b]) stable = 1'b0;
      if (ctl_of(k)[1]) busy_n++;
    end
    @(negedge clk);
    chk({name, "_bits"}, {22'h0, got}, {22'h0, exp});
    chk({name, "_stable"}, {31'h0, stable}, 32'h1);
    chk({name, "_busylen"}, busy_n, 10 * b);
    chk({name, "_ctl_after"}, ctl_of(k), 32'h0);
    chk({name, "_tx_after"}, {31'h0, tx_of(k)}, 32'h1);
  endtask

  initial begin
    int gap;
    int waited;
    rst_n = 1'b0; wr_c = 1'b0; wr_d = 1'b0; wdata = 32'h0; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_tx",  {31'h0, tx0}, 32'h1);
    chk("rst_ctl", ctl0, 32'h0);
    chk("rst_dat", dat0, 32'h0);
    repeat (20) @(negedge clk);
    chk("idle_tx", {31'h0, tx0}, 32'h1);

    // 0xA5 frame; data 0x3C and a send write land mid-frame
    bus_write(1'b0, 1'b1, 32'h0000_00A5);
    bus_write(1'b1, 1'b0, 32'h0000_0001);
    chk("send_vis", ctl0, 32'h1);
    fork
      capture(0, {1'b1, 8'hA5, 1'b0}, "frameA5");
      begin
        repeat (8) @(negedge clk);
        bus_write(1'b0, 1'b1, 32'h0000_003C);
        bus_write(1'b1, 1'b0, 32'h0000_0001);
      end
    join
    chk("dat_3C", dat0, 32'h0000_003C);
    bus_write(1'b1, 1'b0, 32'h0000_0001);
    capture(0, {1'b1, 8'h3C, 1'b0}, "frame3C");

    // simultaneous strobes send the old byte
    repeat (2) @(negedge clk);
    bus_write(1'b0, 1'b1, 32'h0000_0000);
    bus_write(1'b1, 1'b1, 32'h0000_0081);
    chk("both_dat", dat0, 32'h0000_0081);
    chk("both_ctl", ctl0, 32'h0000_0001);
    capture(0, {1'b1, 8'h00, 1'b0}, "frame00");

    // reset in the middle of data bit 3 of 0x81
    repeat (2) @(negedge clk);
    bus_write(1'b1, 1'b0, 32'h0000_0001);
    waited = 0;
    while (!ctl0[1] && waited < 20) begin @(negedge clk); waited++; end
    if (!ctl0[1]) timeout("mid_rst_busy");
    repeat (17) @(negedge clk);
    chk("pre_rst_tx",  {31'h0, tx0}, 32'h0);
    chk("pre_rst_ctl", ctl0, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx",  {31'h0, tx0}, 32'h1);
    chk("rst_mid_ctl", ctl0, 32'h0);
    chk("rst_mid_dat", dat0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_write(1'b0, 1'b1, 32'h0000_005A);
    bus_write(1'b1, 1'b0, 32'h0000_0001);
    capture(0, {1'b1, 8'h5A, 1'b0}, "frame5A");

    // back-to-back frames on the BAUD_DIV=2 instance
    repeat (2) @(negedge clk);
    bus_write(1'b0, 1'b1, 32'h0000_0096);
    bus_write(1'b1, 1'b0, 32'h0000_0001);
    waited = 0;
    while (!ctl1[1] && waited < 20) begin @(negedge clk); waited++; end
    if (!ctl1[1]) timeout("b2b_first_start");
    waited = 0;
    while (ctl1[1] && waited < 40) begin @(negedge clk); waited++; end
    if (ctl1[1]) timeout("b2b_first_end");
    wr_c = 1'b1; wdata = 32'h0000_0001;
    gap = 0;
    while (tx1 && gap < 10) begin
      gap++;
      @(negedge clk);
      wr_c = 1'b0; wdata = 32'h0;
    end
    wr_c = 1'b0; wdata = 32'h0;
    chk("b2b_gap", gap, 2);
    capture(1, {1'b1, 8'h96, 1'b0}, "b2b_second");

    repeat (45) @(negedge clk);
    chk("end_tx", {31'h0, tx0}, 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
